// File: rtl/serial_comparator_rl.sv
`default_nettype none
// ============================================================================
// Module      : serial_comparator_rl
// Description : Bit-serial magnitude comparator. Captures two K-bit operands
//               on an accepted start, scans them one bit per clock from LSB
//               to MSB, and reports A>B, A<B or A==B with a one-cycle done
//               pulse. A more significant differing bit overrides any
//               decision taken on a less significant bit.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               start    - comparison request, sampled only while idle
//               A_valor  - operand A, captured on the accepted start edge
//               B_valor  - operand B, captured on the accepted start edge
//               busy     - high while the bits are being scanned and for the
//                          result cycle; start is ignored while high
//               done     - one-cycle pulse, result flags valid from here on
//               A_mayor  - result A > B
//               B_mayor  - result A < B
//               iguales  - result A == B
// Revision    : 1.0 - initial release
// ============================================================================
module serial_comparator_rl #(
    parameter int K     = 2,
    parameter int CNT_W = $clog2(K + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [K-1:0] A_valor,
    input  logic [K-1:0] B_valor,
    output logic         busy,
    output logic         done,
    output logic         A_mayor,
    output logic         B_mayor,
    output logic         iguales
);

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_shift = 2'd1;
    localparam logic [1:0] c_s_done  = 2'd2;

    localparam logic [1:0] c_dec_eq = 2'd0;
    localparam logic [1:0] c_dec_gt = 2'd1;
    localparam logic [1:0] c_dec_lt = 2'd2;

    // Count value seen while the MSB sits at position 0 of the shift regs.
    localparam logic [CNT_W-1:0] c_last = CNT_W'(K - 1);

    logic [1:0]       r_state;
    logic [K-1:0]     r_sa;
    logic [K-1:0]     r_sb;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_dec;
    logic             r_busy;
    logic             r_done;
    logic             r_a_mayor;
    logic             r_b_mayor;
    logic             r_iguales;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_s_idle;
            r_sa      <= '0;
            r_sb      <= '0;
            r_cnt     <= '0;
            r_dec     <= c_dec_eq;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_a_mayor <= 1'b0;
            r_b_mayor <= 1'b0;
            r_iguales <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_s_idle: begin
                    if (start) begin
                        r_sa      <= A_valor;
                        r_sb      <= B_valor;
                        r_cnt     <= '0;
                        r_dec     <= c_dec_eq;
                        r_a_mayor <= 1'b0;
                        r_b_mayor <= 1'b0;
                        r_iguales <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= c_s_shift;
                    end
                end
                c_s_shift: begin
                    // Bits arrive LSB first, so any difference found now is
                    // more significant than the one already recorded and
                    // simply replaces it; equal bits keep the old decision.
                    if (r_sa[0] && !r_sb[0]) begin
                        r_dec <= c_dec_gt;
                    end else if (!r_sa[0] && r_sb[0]) begin
                        r_dec <= c_dec_lt;
                    end
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= c_s_done;
                    end
                end
                c_s_done: begin
                    // Flags and done land together as the FSM returns to
                    // idle, so the result is visible in the first idle cycle.
                    r_done    <= 1'b1;
                    r_a_mayor <= (r_dec == c_dec_gt);
                    r_b_mayor <= (r_dec == c_dec_lt);
                    r_iguales <= (r_dec == c_dec_eq);
                    r_busy    <= 1'b0;
                    r_state   <= c_s_idle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_s_idle;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign A_mayor = r_a_mayor;
    assign B_mayor = r_b_mayor;
    assign iguales = r_iguales;

endmodule
`default_nettype wire

// File: tb/tb_serial_comparator_rl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_comparator_rl
// Description : Scoreboard bench for serial_comparator_rl. Three instances
//               (K=1, K=2, K=4) share clock and reset. Stimulus tasks push
//               the hand-computed result and the cycle in which done must
//               appear; a negedge monitor pops and compares on every done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_comparator_rl;

    typedef struct {
        logic [2:0] f;    // {A_mayor, B_mayor, iguales}
        int         due;  // edge count at which done must be visible
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] st = 3'b000;
    logic [0:0] a1 = '0, b1 = '0;
    logic [1:0] a2 = '0, b2 = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [2:0] busy, done, am, bm, ig;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bcnt = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_comparator_rl #(.K(1)) u_k1 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .A_valor(a1), .B_valor(b1),
        .busy(busy[0]), .done(done[0]), .A_mayor(am[0]), .B_mayor(bm[0]), .iguales(ig[0])
    );
    serial_comparator_rl #(.K(2)) u_k2 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .A_valor(a2), .B_valor(b2),
        .busy(busy[1]), .done(done[1]), .A_mayor(am[1]), .B_mayor(bm[1]), .iguales(ig[1])
    );
    serial_comparator_rl #(.K(4)) u_k4 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .A_valor(a4), .B_valor(b4),
        .busy(busy[2]), .done(done[2]), .A_mayor(am[2]), .B_mayor(bm[2]), .iguales(ig[2])
    );

    function automatic int kof(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 2 : 4;
    endfunction

    function automatic int qsize(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int idx, input logic [2:0] f, input int due);
        exp_t e;
        e.f   = f;
        e.due = due;
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop(input int idx, output exp_t e);
        case (idx)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic set_ops(input int idx, input logic [3:0] a, input logic [3:0] b);
        case (idx)
            0:       begin a1 = a[0:0]; b1 = b[0:0]; end
            1:       begin a2 = a[1:0]; b2 = b[1:0]; end
            default: begin a4 = a;      b4 = b;      end
        endcase
    endtask

    // Monitor: every done must match the head of its queue, in value and in
    // cycle; a head whose due cycle passes without done is a missed result.
    task automatic chk(input int idx);
        exp_t e;
        if (done[idx]) begin
            checks++;
            if (qsize(idx) == 0) begin
                errors++;
                $display("FAIL unexpected_done k%0d: got done with flags %b, required no done",
                         kof(idx), {am[idx], bm[idx], ig[idx]});
            end else begin
                pop(idx, e);
                if ({am[idx], bm[idx], ig[idx]} !== e.f || cyc != e.due) begin
                    errors++;
                    $display("FAIL result k%0d: got flags %b at edge %0d, required %b at edge %0d",
                             kof(idx), {am[idx], bm[idx], ig[idx]}, cyc, e.f, e.due);
                end
            end
        end else if (qsize(idx) != 0) begin
            case (idx)
                0:       e = q0[0];
                1:       e = q1[0];
                default: e = q2[0];
            endcase
            if (cyc >= e.due) begin
                pop(idx, e);
                checks++;
                errors++;
                $display("FAIL missed_done k%0d: got no done at edge %0d, required flags %b",
                         kof(idx), cyc, e.f);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) chk(i);
            if (busy[2]) bcnt++;
        end
    end

    // Pulse start for one accepted edge and record the expected outcome.
    task automatic run_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] f);
        @(negedge clk);
        set_ops(idx, a, b);
        st[idx] = 1'b1;
        @(posedge clk);
        #1;
        st[idx] = 1'b0;
        push(idx, f, cyc + kof(idx) + 1);
    endtask

    task automatic wait_idle(input int idx);
        for (int n = 0; n < 30; n++) begin
            if (qsize(idx) == 0) break;
            @(negedge clk);
            #1;
        end
        if (qsize(idx) != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout k%0d: got %0d pending results, required 0", kof(idx), qsize(idx));
            case (idx)
                0:       q0.delete();
                1:       q1.delete();
                default: q2.delete();
            endcase
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({busy, done, am, bm, ig} !== 15'd0) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b am=%b bm=%b ig=%b, required all 0",
                     name, busy, done, am, bm, ig);
        end
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A=11 B=00 -> A greater, done three edges after acceptance
        run_op(1, 4'b0011, 4'b0000, 3'b100);
        wait_idle(1);
        // Back-to-back sequence; flags are cleared and rewritten each time
        run_op(1, 4'b0011, 4'b0001, 3'b100);
        wait_idle(1);
        run_op(1, 4'b0011, 4'b0010, 3'b100);
        wait_idle(1);
        run_op(1, 4'b0011, 4'b0011, 3'b001);
        wait_idle(1);
        // LSB says A<B, MSB overrides to A>B
        run_op(1, 4'b0010, 4'b0001, 3'b100);
        wait_idle(1);

        // K=4, 0011 vs 1000 -> B greater; busy high K+1 = 5 cycles
        bcnt = 0;
        run_op(2, 4'b0011, 4'b1000, 3'b010);
        wait_idle(2);
        checks++;
        if (bcnt != 5) begin
            errors++;
            $display("FAIL busy_len: got %0d cycles, required 5", bcnt);
        end

        // Restart attempt with new operands mid-scan is ignored
        run_op(2, 4'b0101, 4'b0110, 3'b010);
        @(negedge clk);
        set_ops(2, 4'b1111, 4'b0000);
        st[2] = 1'b1;
        @(negedge clk);
        st[2] = 1'b0;
        wait_idle(2);
        repeat (4) @(negedge clk);

        // Start held high: second accept K+2 edges after the first, and the
        // operand change after the first capture only affects the second
        @(negedge clk);
        set_ops(1, 4'b0010, 4'b0010);
        st[1] = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        push(1, 3'b001, t + 3);
        set_ops(1, 4'b0001, 4'b0010);
        repeat (4) @(posedge clk);
        #1;
        push(1, 3'b010, t + 7);
        st[1] = 1'b0;
        wait_idle(1);

        // K=1 results, latency 2 edges
        run_op(0, 4'b0001, 4'b0000, 3'b100);
        wait_idle(0);
        run_op(0, 4'b0000, 4'b0001, 3'b010);
        wait_idle(0);

        // Asynchronous reset in the middle of a K=4 scan
        @(negedge clk);
        set_ops(2, 4'b1001, 4'b0110);
        st[2] = 1'b1;
        @(posedge clk);
        #1;
        st[2] = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_scan: got %b, required 1", busy[2]);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal operation after release, both widths
        run_op(2, 4'b1001, 4'b0110, 3'b100);
        wait_idle(2);
        run_op(0, 4'b0001, 4'b0001, 3'b001);
        wait_idle(0);
        run_op(1, 4'b0001, 4'b0010, 3'b010);
        wait_idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
